// File: rtl/mem_rr_bank.sv
// mem_rr_bank: single-port memory shared by NUM_PORTS round-robin requesters.
// Define MEM_BYTE_EN_EN to add per-byte write strobes (wstrb).
module mem_rr_bank #(
    parameter int NUM_PORTS  = 2,
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int RD_LAT     = 1,
    parameter int PID_W      = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            valid,
    input  logic [NUM_PORTS-1:0]            wr_rd,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr,
    input  logic [NUM_PORTS*WIDTH-1:0]      wdata,
`ifdef MEM_BYTE_EN_EN
    input  logic [NUM_PORTS*(WIDTH/8)-1:0]  wstrb,
`endif
    output logic [NUM_PORTS-1:0]            ready,
    output logic [WIDTH-1:0]                rdata,
    output logic                            rvalid,
    output logic [PID_W-1:0]                rid
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    if (NUM_PORTS < 1 || NUM_PORTS > 8) begin : g_bad_ports
        $error("mem_rr_bank: NUM_PORTS must be 1..8");
    end
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
        $error("mem_rr_bank: RD_LAT must be 1..4");
    end
    if ((1 << PID_W) < NUM_PORTS) begin : g_bad_pid
        $error("mem_rr_bank: PID_W too narrow for NUM_PORTS");
    end
`ifdef MEM_BYTE_EN_EN
    if (WIDTH % 8 != 0) begin : g_bad_width
        $error("mem_rr_bank: WIDTH must be a multiple of 8");
    end
`endif

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [PID_W-1:0]      ptr;
    logic                  xfer;
    logic                  g_wr;
    logic [ADDR_WIDTH-1:0] g_addr;
    logic [WIDTH-1:0]      g_wdata;
    logic [PID_W-1:0]      g_id;
    int                    best;
`ifdef MEM_BYTE_EN_EN
    logic [WIDTH/8-1:0]    g_strb;
`endif

    logic                  pv [RD_LAT];
    logic [WIDTH-1:0]      pd [RD_LAT];
    logic [PID_W-1:0]      pt [RD_LAT];

    // Distance of port i from the current priority pointer.
    function automatic int rr_dist(input int i, input logic [PID_W-1:0] p);
        return (i + NUM_PORTS - int'(p)) % NUM_PORTS;
    endfunction

    always_comb begin
        ready = '0;
        best  = NUM_PORTS;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (valid[i] && rr_dist(i, ptr) < best) begin
                best = rr_dist(i, ptr);
            end
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (rst && valid[i] && rr_dist(i, ptr) == best) begin
                ready[i] = 1'b1;
            end
        end
    end

    always_comb begin
        g_wr    = 1'b0;
        g_addr  = '0;
        g_wdata = '0;
        g_id    = '0;
`ifdef MEM_BYTE_EN_EN
        g_strb  = '0;
`endif
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (ready[i]) begin
                g_wr    = wr_rd[i];
                g_addr  = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                g_wdata = wdata[i*WIDTH +: WIDTH];
                g_id    = PID_W'(i);
`ifdef MEM_BYTE_EN_EN
                g_strb  = wstrb[i*(WIDTH/8) +: WIDTH/8];
`endif
            end
        end
    end

    assign xfer = |ready;

    // Array is deliberately left out of reset so contents survive it.
    always_ff @(posedge clk) begin
        if (xfer && g_wr) begin
`ifdef MEM_BYTE_EN_EN
            for (int b = 0; b < WIDTH/8; b++) begin
                if (g_strb[b]) begin
                    mem[g_addr][b*8 +: 8] <= g_wdata[b*8 +: 8];
                end
            end
`else
            mem[g_addr] <= g_wdata;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
            for (int s = 0; s < RD_LAT; s++) begin
                pv[s] <= 1'b0;
                pd[s] <= '0;
                pt[s] <= '0;
            end
        end else begin
            if (xfer) begin
                if (int'(g_id) == NUM_PORTS - 1) begin
                    ptr <= '0;
                end else begin
                    ptr <= g_id + 1'b1;
                end
            end
            pv[0] <= xfer && !g_wr;
            if (xfer && !g_wr) begin
                pd[0] <= mem[g_addr];
                pt[0] <= g_id;
            end
            // Data/tag only advance with a valid so outputs hold between pulses.
            for (int s = 1; s < RD_LAT; s++) begin
                pv[s] <= pv[s-1];
                if (pv[s-1]) begin
                    pd[s] <= pd[s-1];
                    pt[s] <= pt[s-1];
                end
            end
        end
    end

    assign rvalid = pv[RD_LAT-1];
    assign rdata  = pd[RD_LAT-1];
    assign rid    = pt[RD_LAT-1];

endmodule

// File: tb/tb_mem_rr_bank.sv
// tb_mem_rr_bank: directed bench for mem_rr_bank at RD_LAT=1 and RD_LAT=3.
// Both instances share stimulus; byte-strobe steps follow MEM_BYTE_EN_EN.
module tb_mem_rr_bank;

    localparam int NP = 2;
    localparam int W  = 32;
    localparam int AW = 8;
    localparam int PW = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [NP-1:0]    valid;
    logic [NP-1:0]    wr_rd;
    logic [NP*AW-1:0] addr;
    logic [NP*W-1:0]  wdata;
`ifdef MEM_BYTE_EN_EN
    logic [NP*(W/8)-1:0] wstrb;
`endif

    logic [NP-1:0] ready1, ready3;
    logic [W-1:0]  rdata1, rdata3;
    logic          rvalid1, rvalid3;
    logic [PW-1:0] rid1, rid3;

    int n_cmp = 0;
    int n_bad = 0;

    mem_rr_bank #(
        .NUM_PORTS(NP), .WIDTH(W), .ADDR_WIDTH(AW), .RD_LAT(1), .PID_W(PW)
    ) dut1 (
        .clk(clk), .rst(rst), .valid(valid), .wr_rd(wr_rd),
        .addr(addr), .wdata(wdata),
`ifdef MEM_BYTE_EN_EN
        .wstrb(wstrb),
`endif
        .ready(ready1), .rdata(rdata1), .rvalid(rvalid1), .rid(rid1)
    );

    mem_rr_bank #(
        .NUM_PORTS(NP), .WIDTH(W), .ADDR_WIDTH(AW), .RD_LAT(3), .PID_W(PW)
    ) dut3 (
        .clk(clk), .rst(rst), .valid(valid), .wr_rd(wr_rd),
        .addr(addr), .wdata(wdata),
`ifdef MEM_BYTE_EN_EN
        .wstrb(wstrb),
`endif
        .ready(ready3), .rdata(rdata3), .rvalid(rvalid3), .rid(rid3)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input int p, input logic wr,
                       input logic [AW-1:0] a, input logic [W-1:0] d);
        valid[p] = 1'b1;
        wr_rd[p] = wr;
        addr[p*AW +: AW] = a;
        wdata[p*W +: W] = d;
    endtask

    task automatic idle();
        valid = '0;
        wr_rd = '0;
    endtask

    initial begin
        valid = 2'b11;
        wr_rd = '0;
        addr  = '0;
        wdata = '0;
`ifdef MEM_BYTE_EN_EN
        wstrb = '1;
`endif
        // Reset state, requests held during reset must not be granted
        tick();
        tick();
        chk("rst_ready", 64'(ready1), 64'h0);
        chk("rst_rvalid", 64'(rvalid1), 64'h0);
        chk("rst_rdata", 64'(rdata1), 64'h0);
        chk("rst_rid", 64'(rid1), 64'h0);
        chk("rst_rvalid3", 64'(rvalid3), 64'h0);
        idle();
        rst = 1'b1;
        tick();

        // Port 0 write then read of 0x10
        req(0, 1'b1, 8'h10, 32'hDEADBEEF);
        #1 chk("t1_wr_ready", 64'(ready1), 64'h1);
        tick();
        req(0, 1'b0, 8'h10, 32'h0);
        #1 chk("t1_rd_ready", 64'(ready1), 64'h1);
        chk("t1_no_rvalid", 64'(rvalid1), 64'h0);
        tick();
        idle();
        chk("t1_rvalid", 64'(rvalid1), 64'h1);
        chk("t1_rdata", 64'(rdata1), 64'hDEADBEEF);
        chk("t1_rid", 64'(rid1), 64'h0);
        tick();
        chk("t1_pulse", 64'(rvalid1), 64'h0);
        chk("t1_hold", 64'(rdata1), 64'hDEADBEEF);

        // Pre-writes: ptr=1 -> p0 alone wins, ptr stays 1; p1 wins, ptr=0
        req(0, 1'b1, 8'h01, 32'h11);
        tick();
        idle();
        req(1, 1'b1, 8'h02, 32'h22);
        tick();
        idle();

        // Only port 1 valid with ptr=0
        req(1, 1'b0, 8'h02, 32'h0);
        #1 chk("t6_ready", 64'(ready1), 64'h2);
        tick();
        chk("t6_rvalid", 64'(rvalid1), 64'h1);
        chk("t6_rid", 64'(rid1), 64'h1);
        chk("t6_rdata", 64'(rdata1), 64'h22);

        // Both ports reading: grants alternate 0,1,0,1 from wrapped ptr
        req(0, 1'b0, 8'h01, 32'h0);
        for (int i = 0; i < 4; i++) begin
            #1 chk("t2_ready", 64'(ready1), 64'(1 << (i % 2)));
            tick();
            chk("t2_rvalid", 64'(rvalid1), 64'h1);
            chk("t2_rid", 64'(rid1), 64'(i % 2));
            chk("t2_rdata", 64'(rdata1), (i % 2) ? 64'h22 : 64'h11);
        end
        idle();
        tick();
        chk("t2_end", 64'(rvalid1), 64'h0);

        // RD_LAT=3: write then read 0x20 from port 1
        req(1, 1'b1, 8'h20, 32'h5A5A5A5A);
        #1 chk("t3_wr_ready", 64'(ready3), 64'h2);
        tick();
        req(1, 1'b0, 8'h20, 32'h0);
        #1 chk("t3_rd_ready", 64'(ready3), 64'h2);
        tick();
        idle();
        chk("t3_haz_rvalid1", 64'(rvalid1), 64'h1);
        chk("t3_haz_rdata1", 64'(rdata1), 64'h5A5A5A5A);
        chk("t3_haz_rid1", 64'(rid1), 64'h1);
        chk("t3_lat_c1", 64'(rvalid3), 64'h0);
        tick();
        chk("t3_lat_c2", 64'(rvalid3), 64'h0);
        tick();
        chk("t3_rvalid3", 64'(rvalid3), 64'h1);
        chk("t3_rdata3", 64'(rdata3), 64'h5A5A5A5A);
        chk("t3_rid3", 64'(rid3), 64'h1);
        tick();
        chk("t3_pulse3", 64'(rvalid3), 64'h0);
        chk("t3_hold3", 64'(rdata3), 64'h5A5A5A5A);

        // Reset while a RD_LAT=3 read is in flight; ptr moved to 1 first
        req(0, 1'b0, 8'h10, 32'h0);
        #1 chk("t4_rd_ready", 64'(ready3), 64'h1);
        tick();
        idle();
        rst = 1'b0;
        #1 chk("t4_rst_rvalid3", 64'(rvalid3), 64'h0);
        chk("t4_rst_rdata3", 64'(rdata3), 64'h0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_dropped", 64'(rvalid3), 64'h0);
        end
        req(0, 1'b0, 8'h10, 32'h0);
        req(1, 1'b0, 8'h20, 32'h0);
        #1 chk("t4_ptr0", 64'(ready1), 64'h1);
        tick();
        chk("t4_keep_rdata", 64'(rdata1), 64'hDEADBEEF);
        chk("t4_keep_rid", 64'(rid1), 64'h0);
        #1 chk("t4_next_ready", 64'(ready1), 64'h2);
        tick();
        idle();
        chk("t4_keep_rdata2", 64'(rdata1), 64'h5A5A5A5A);
        chk("t4_keep_rid2", 64'(rid1), 64'h1);
        tick();

        // Partial or full-word write merge at 0x30
        req(0, 1'b1, 8'h30, 32'hFFFFFFFF);
        tick();
        req(0, 1'b1, 8'h30, 32'h12345678);
`ifdef MEM_BYTE_EN_EN
        wstrb[3:0] = 4'b0101;
`endif
        tick();
        req(0, 1'b0, 8'h30, 32'h0);
        tick();
        idle();
        chk("t5_rvalid", 64'(rvalid1), 64'h1);
`ifdef MEM_BYTE_EN_EN
        chk("t5_strb_rdata", 64'(rdata1), 64'hFF34FF78);
`else
        chk("t5_full_rdata", 64'(rdata1), 64'h12345678);
`endif
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
